// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute/memory pipeline stage with a blocking data-memory handshake.
// ALU-only instructions produce write-back one cycle after accept. Aligned loads and
// stores go to WAIT until the memory acknowledges. Misaligned memory ops produce a
// one-cycle misalign pulse and do not issue a request.
//
// Handshake: an instruction is taken on a rising edge where in_valid & in_ready.
// in_valid while in_ready=0 is ignored. mem_req is held, with constant addr/data/we,
// until a one-cycle mem_ack is sampled. A mem_ack outside WAIT is ignored.
//
// Optional feature: define EXMEM_FWD_EN to drive the fwd_* outputs from the
// write-back result. Without it, fwd_* are tied to zero.
// o_dbg_state exposes the FSM state for observation.
module ex_mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_ALU,
  input  logic [31:0] in_dato_registro,
  input  logic [4:0]  in_sel_reg,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic        REG_WRITE,
  output logic        in_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        fwd_valid,
  output logic [4:0]  fwd_reg,
  output logic [31:0] fwd_data,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  state_t      w_accept_dest;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [4:0]  r_reg;
  logic        r_we;
  logic        r_mis;
  logic        r_wb_regw;
  logic [31:0] r_wb_data;

  logic        w_ready;
  logic        w_accept;
  logic        w_is_mem;
  logic        w_mis;

  assign w_ready  = (r_state != S_WAIT);
  assign w_accept = in_valid & w_ready;
  assign w_is_mem = MEM_READ | MEM_WRITE;
  assign w_mis    = w_is_mem & (in_ALU[1:0] != 2'b00);

  // Where a freshly accepted instruction goes: aligned memory ops wait, all else completes.
  always_comb begin
    w_accept_dest = S_DONE;
    if (w_is_mem && !w_mis) w_accept_dest = S_WAIT;
  end

  // Next-state logic. DONE is always a single cycle unless a new instruction is taken.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_accept_dest;
      S_WAIT:  if (mem_ack) w_next = S_DONE;
      S_DONE:  w_next = w_accept ? w_accept_dest : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register. Reset wins over accept and mem_ack.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Latch the instruction on accept. Capture load data when the memory acknowledges.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_reg     <= 5'd0;
      r_we      <= 1'b0;
      r_mis     <= 1'b0;
      r_wb_regw <= 1'b0;
      r_wb_data <= 32'd0;
    end else if (w_accept) begin
      r_addr    <= in_ALU;
      r_wdata   <= in_dato_registro;
      r_reg     <= in_sel_reg;
      r_we      <= MEM_WRITE;
      r_mis     <= w_mis;
      // Stores (including read+write) and misaligned ops never write; r0 is never written.
      r_wb_regw <= REG_WRITE & ~MEM_WRITE & ~w_mis & (in_sel_reg != 5'd0);
      r_wb_data <= in_ALU;
    end else if ((r_state == S_WAIT) && mem_ack && !r_we) begin
      r_wb_data <= mem_rdata;
    end
  end

  assign in_ready     = w_ready;
  assign mem_req      = (r_state == S_WAIT);
  assign mem_we       = mem_req & r_we;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign wb_valid     = (r_state == S_DONE);
  assign wb_reg_write = wb_valid & r_wb_regw;
  assign wb_reg       = r_reg;
  assign wb_data      = r_wb_data;
  assign misalign     = wb_valid & r_mis;
  assign o_dbg_state  = r_state;

`ifdef EXMEM_FWD_EN
  assign fwd_valid = wb_valid & wb_reg_write;
  assign fwd_reg   = wb_reg;
  assign fwd_data  = wb_data;
`else
  assign fwd_valid = 1'b0;
  assign fwd_reg   = 5'd0;
  assign fwd_data  = 32'd0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed cases followed by randomized instructions.
// Every instruction is checked against expectations derived from its fields and
// the memory response given to it.
module tb_ex_mem_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_ALU;
  logic [31:0] in_dato_registro;
  logic [4:0]  in_sel_reg;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic        REG_WRITE;
  logic        in_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        misalign;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic [1:0]  o_dbg_state;

  int errors;
  int checks;

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ALU           (in_ALU),
    .in_dato_registro (in_dato_registro),
    .in_sel_reg       (in_sel_reg),
    .MEM_READ         (MEM_READ),
    .MEM_WRITE        (MEM_WRITE),
    .REG_WRITE        (REG_WRITE),
    .in_ready         (in_ready),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_ack          (mem_ack),
    .wb_valid         (wb_valid),
    .wb_reg_write     (wb_reg_write),
    .wb_reg           (wb_reg),
    .wb_data          (wb_data),
    .misalign         (misalign),
    .fwd_valid        (fwd_valid),
    .fwd_reg          (fwd_reg),
    .fwd_data         (fwd_data),
    .o_dbg_state      (o_dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive ignored garbage on the instruction inputs.
  task automatic drive_junk();
    logic [31:0] rnd;
    rnd              = $urandom;
    in_valid         = rnd[0];
    MEM_READ         = rnd[1];
    MEM_WRITE        = rnd[2];
    REG_WRITE        = rnd[3];
    in_sel_reg       = rnd[8:4];
    in_ALU           = $urandom;
    in_dato_registro = $urandom;
  endtask

  // Issue one instruction, let the memory answer after wait_cycles request cycles,
  // and check the write-back cycle. Returns at the falling edge of the result cycle.
  task automatic run_instr(input logic rd, input logic wr, input logic rw,
                           input logic [31:0] alu, input logic [31:0] data,
                           input logic [4:0] sel, input int wait_cycles,
                           input logic [31:0] rdata);
    logic        is_mem;
    logic        mis;
    logic        exp_rw;
    logic        chk_data;
    logic [31:0] exp_data;
    is_mem   = rd | wr;
    mis      = is_mem && (alu[1:0] != 2'b00);
    exp_rw   = rw && !wr && !mis && (sel != 5'd0);
    chk_data = !is_mem || (!wr && !mis);
    exp_data = is_mem ? rdata : alu;

    chk("ready_before_issue", 32'(in_ready), 32'd1);
    in_valid         = 1'b1;
    MEM_READ         = rd;
    MEM_WRITE        = wr;
    REG_WRITE        = rw;
    in_ALU           = alu;
    in_dato_registro = data;
    in_sel_reg       = sel;
    step();
    in_valid = 1'b0;

    if (is_mem && !mis) begin
      for (int k = 0; k < wait_cycles; k++) begin
        chk("wait_mem_req", 32'(mem_req), 32'd1);
        chk("wait_mem_we", 32'(mem_we), 32'(wr));
        chk("wait_mem_addr", mem_addr, alu);
        chk("wait_mem_wdata", mem_wdata, data);
        chk("wait_in_ready", 32'(in_ready), 32'd0);
        chk("wait_wb_valid", 32'(wb_valid), 32'd0);
        drive_junk();
        if (k == wait_cycles - 1) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
        end
        step();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        in_valid  = 1'b0;
      end
    end

    chk("done_wb_valid", 32'(wb_valid), 32'd1);
    chk("done_wb_reg", 32'(wb_reg), 32'(sel));
    chk("done_wb_reg_write", 32'(wb_reg_write), 32'(exp_rw));
    chk("done_misalign", 32'(misalign), 32'(mis));
    chk("done_mem_req", 32'(mem_req), 32'd0);
    chk("done_in_ready", 32'(in_ready), 32'd1);
    if (chk_data) chk("done_wb_data", wb_data, exp_data);
`ifdef EXMEM_FWD_EN
    chk("done_fwd_valid", 32'(fwd_valid), 32'(exp_rw));
    chk("done_fwd_reg", 32'(fwd_reg), 32'(sel));
    if (chk_data) chk("done_fwd_data", fwd_data, exp_data);
`else
    chk("done_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("done_fwd_reg", 32'(fwd_reg), 32'd0);
    chk("done_fwd_data", fwd_data, 32'd0);
`endif
  endtask

  // One cycle with nothing issued and a stray ack that must be ignored.
  task automatic idle_check();
    logic [31:0] rnd;
    rnd       = $urandom;
    in_valid  = 1'b0;
    mem_ack   = rnd[0];
    mem_rdata = $urandom;
    step();
    mem_ack = 1'b0;
    chk("idle_wb_valid", 32'(wb_valid), 32'd0);
    chk("idle_mem_req", 32'(mem_req), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_misalign", 32'(misalign), 32'd0);
    chk("idle_fwd_valid", 32'(fwd_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] alu;
    errors           = 0;
    checks           = 0;
    reset            = 1'b1;
    in_valid         = 1'b0;
    in_ALU           = 32'd0;
    in_dato_registro = 32'd0;
    in_sel_reg       = 5'd0;
    MEM_READ         = 1'b0;
    MEM_WRITE        = 1'b0;
    REG_WRITE        = 1'b0;
    mem_rdata        = 32'd0;
    mem_ack          = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset values
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_wb_reg", 32'(wb_reg), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_fwd_reg", 32'(fwd_reg), 32'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);

    // ALU op to r5
    run_instr(1'b0, 1'b0, 1'b1, 32'h0000_0007, 32'h5555_AAAA, 5'd5, 0, 32'd0);
    idle_check();
    // Load from 0x100, ack after three request cycles
    run_instr(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 5'd8, 3, 32'hDEAD_BEEF);
    idle_check();
    // Store to 0x104; REG_WRITE set but a store never writes back
    run_instr(1'b0, 1'b1, 1'b1, 32'h0000_0104, 32'h0000_1234, 5'd6, 2, 32'hFFFF_FFFF);
    idle_check();
    // Misaligned load
    run_instr(1'b1, 1'b0, 1'b1, 32'h0000_0102, 32'h0, 5'd7, 0, 32'd0);
    idle_check();
    // Read and write both set behaves as a store
    run_instr(1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'hCAFE_0001, 5'd9, 1, 32'h0BAD_0BAD);
    idle_check();
    // Write to r0 is suppressed
    run_instr(1'b0, 1'b0, 1'b1, 32'h0000_0042, 32'h0, 5'd0, 0, 32'd0);
    idle_check();
    // Back-to-back ALU ops to r3 then r4, then a load accepted in DONE
    run_instr(1'b0, 1'b0, 1'b1, 32'h0000_0033, 32'h0, 5'd3, 0, 32'd0);
    run_instr(1'b0, 1'b0, 1'b1, 32'h0000_0044, 32'h0, 5'd4, 0, 32'd0);
    run_instr(1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0, 5'd12, 1, 32'h1357_9BDF);
    idle_check();

    // Reset in the second request cycle of a load; ack arrives the cycle after
    in_valid   = 1'b1;
    MEM_READ   = 1'b1;
    MEM_WRITE  = 1'b0;
    REG_WRITE  = 1'b1;
    in_ALU     = 32'h0000_0100;
    in_sel_reg = 5'd10;
    step();
    in_valid = 1'b0;
    chk("rstwait_req_c1", 32'(mem_req), 32'd1);
    step();
    chk("rstwait_req_c2", 32'(mem_req), 32'd1);
    reset = 1'b1;
    step();
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h7777_7777;
    chk("rstwait_req_after", 32'(mem_req), 32'd0);
    chk("rstwait_ready_after", 32'(in_ready), 32'd1);
    chk("rstwait_wb_after", 32'(wb_valid), 32'd0);
    step();
    mem_ack = 1'b0;
    chk("rstwait_req_ack", 32'(mem_req), 32'd0);
    chk("rstwait_wb_ack", 32'(wb_valid), 32'd0);

    // Reset wins over an accept
    in_valid  = 1'b1;
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
    in_ALU    = 32'h0000_0099;
    reset     = 1'b1;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("rst_over_accept_wb", 32'(wb_valid), 32'd0);
    chk("rst_over_accept_ready", 32'(in_ready), 32'd1);

    // Randomized instruction stream
    for (int t = 0; t < 60; t++) begin
      rnd = $urandom;
      alu = $urandom;
      if (rnd[3]) alu[1:0] = 2'b00;
      run_instr(rnd[0], rnd[1], rnd[2], alu, $urandom, rnd[8:4],
                $urandom_range(1, 4), $urandom);
      if (rnd[9]) idle_check();
    end
    idle_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
